// File: rtl/multi_tick_generator_if.sv
// Control and status bundle for multi_tick_generator: per-channel enables,
// global clear, one-cycle config write port, and the tick/done outputs.
interface multi_tick_generator_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] enable;
  logic              clear;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [CNT_W-1:0]  cfg_div;
  logic              cfg_oneshot;
  logic [NUM_CH-1:0] tick_out;
  logic [NUM_CH-1:0] done;

  modport master (
    output enable, clear, cfg_we, cfg_ch, cfg_div, cfg_oneshot,
    input  tick_out, done
  );

  modport slave (
    input  enable, clear, cfg_we, cfg_ch, cfg_div, cfg_oneshot,
    output tick_out, done
  );
endinterface

// File: rtl/multi_tick_generator.sv
// NUM_CH independent tick channels, each with a run-time divisor, a pause
// enable and periodic/one-shot mode. Ticks and done flags are registered.
module multi_tick_generator #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int TICK_FREQ = 100,
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 32
) (
  input logic                   clk,
  input logic                   reset_n,
  multi_tick_generator_if.slave bus
);
  localparam int DEFAULT_DIV = CLK_FREQ / TICK_FREQ;
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] DEFAULT_DIV_W  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DEFAULT_LOAD_W = (DEFAULT_DIV > 1) ? CNT_W'(DEFAULT_DIV - 1) : '0;

  // Each counter runs down from deff-1 and fires on reaching zero, so the
  // terminal compare is a constant and a divisor of 0 or 1 reloads to zero.
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];
  logic [NUM_CH-1:0] oneshot_q, oneshot_d;
  logic [NUM_CH-1:0] done_q, done_d;
  logic [NUM_CH-1:0] tick_q, tick_d;
  logic [NUM_CH-1:0] wr_hit;

  function automatic logic [CNT_W-1:0] reload_of(input logic [CNT_W-1:0] div);
    return (div == '0) ? '0 : div - CNT_W'(1);
  endfunction

  always_comb begin
    wr_hit = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      wr_hit[ch] = bus.cfg_we && (bus.cfg_ch == CH_W'(ch));
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    div_d     = div_q;
    oneshot_d = oneshot_q;
    done_d    = done_q;
    tick_d    = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (wr_hit[ch]) begin
        div_d[ch]     = bus.cfg_div;
        oneshot_d[ch] = bus.cfg_oneshot;
      end
      if (bus.clear || wr_hit[ch]) begin
        cnt_d[ch]  = reload_of(wr_hit[ch] ? bus.cfg_div : div_q[ch]);
        done_d[ch] = 1'b0;
      end else if (bus.enable[ch] && !done_q[ch]) begin
        if (cnt_q[ch] == '0) begin
          cnt_d[ch]  = reload_of(div_q[ch]);
          tick_d[ch] = 1'b1;
          if (oneshot_q[ch]) begin
            done_d[ch] = 1'b1;
          end
        end else begin
          cnt_d[ch] = cnt_q[ch] - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int ch = 0; ch < NUM_CH; ch++) begin
        cnt_q[ch] <= DEFAULT_LOAD_W;
        div_q[ch] <= DEFAULT_DIV_W;
      end
      oneshot_q <= '0;
      done_q    <= '0;
      tick_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      oneshot_q <= oneshot_d;
      done_q    <= done_d;
      tick_q    <= tick_d;
    end
  end

  assign bus.tick_out = tick_q;
  assign bus.done     = done_q;
endmodule

// File: doc/multi_tick_generator.md
# multi_tick_generator

Parametrised multi-channel tick generator, the successor to the single fixed-rate tick source used by the watch/stopwatch datapath. It provides NUM_CH independent single-cycle tick outputs. Each channel has a divisor that can be reprogrammed at run time, a per-channel enable that pauses counting, and a periodic or one-shot mode. A single instance replaces several fixed tick generators, for example the 100 Hz time base, blink timing and UART-driven timeouts.

## Interface
- CLK_FREQ, 100_000_000, input clock frequency in Hz
- TICK_FREQ, 100, default tick rate in Hz; DEFAULT_DIV = CLK_FREQ/TICK_FREQ
- NUM_CH, 4, number of channels (≥1)
- CNT_W, 32, counter/divisor width; DEFAULT_DIV must fit in CNT_W bits
- CH_W (localparam), max(1, $clog2(NUM_CH))

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- enable  in  NUM_CH  per-channel count enable; 0 = pause (count held)
- clear  in  1  synchronous clear of all channel counters and done flags
- cfg_we  in  1  configuration write strobe, one cycle
- cfg_ch  in  CH_W  channel index for the write
- cfg_div  in  CNT_W  new divisor for the channel
- cfg_oneshot  in  1  new mode: 0 = periodic, 1 = one-shot
- tick_out  out  NUM_CH  registered one-cycle tick per channel
- done  out  NUM_CH  one-shot completion flag per channel

## Operation
- Per-channel state: cnt (CNT_W), div (CNT_W), oneshot (1), done (1), tick_out (1).
- Reset values (reset_n low): cnt=0, div=DEFAULT_DIV, oneshot=0, done=0, tick_out=0.
- Effective divisor: deff = (div==0) ? 1 : div. Divisors 0 and 1 both mean "tick every enabled cycle".
- Channel active: enable[ch]=1 and done[ch]=0.
- Active channel: if cnt == deff−1, then cnt←0 and tick_out←1; in one-shot mode, also done←1. Otherwise cnt←cnt+1 and tick_out←0.
- Inactive channel: cnt holds and tick_out←0.
- One-shot: after firing, the channel stays idle with cnt=0 and done=1. It restarts only after a cfg write to that channel or a clear.
- Per-cycle priority for each channel, highest first: reset_n, then clear, then cfg write hit, then counting.
- clear=1: every cnt←0, tick_out←0, done←0. div and oneshot are preserved.
- cfg write hit (cfg_we=1, cfg_ch==ch, cfg_ch<NUM_CH): div←cfg_div, oneshot←cfg_oneshot, cnt←0, done←0, tick_out←0. Counting resumes the next cycle.
- Writes with cfg_ch ≥ NUM_CH are ignored and no state changes.
- clear and cfg_we in the same cycle: both take effect. Target channel gets the new config; all channels get cnt=0, done=0.
- Channels are fully independent; a write to one channel never perturbs another.

## Timing
- tick_out is registered. It is high for exactly one cycle, in the cycle after the edge at which cnt==deff−1 was sampled.
- Periodic, enable held at 1: tick period = deff cycles exactly, with no drift.
- First tick after reset release, clear, or cfg write: tick_out is high after the deff-th enabled rising edge.
- Pausing: low-enable cycles extend the interval by exactly that many cycles; the count is not lost.
- If enable drops in the cycle where cnt==deff−1, no tick fires; the tick fires on the first enabled cycle afterwards.
- deff=1, enable held high: tick_out stays high continuously from the first edge.
- done rises in the same cycle as the one-shot tick_out pulse and stays high.
- Reset mid-count: all outputs go to 0 immediately (asynchronous). On release, counting restarts from 0 with DEFAULT_DIV.
- cnt wrap-around cannot occur, since cnt ≤ deff−1 ≤ 2^CNT_W−2. div = 2^CNT_W−1 must still function correctly.

## Test plan
- Reset/default: CLK_FREQ=1000, TICK_FREQ=100 (DEFAULT_DIV=10), NUM_CH=4, all enabled -> all tick_out pulse at cycles 10, 20, 30…, one cycle wide; done=0.
- Per-channel divisors: write div 3, 5, 1, 0 to ch0–ch3 -> ch0 ticks every 3 cycles, ch1 every 5, ch2 and ch3 high every cycle.
- Pause: ch0 div=8, enable[0] low for 4 cycles after cnt reaches 5 -> tick at 12 cycles after the write instead of 8; next period is 8.
- One-shot: ch1 cfg_div=6, cfg_oneshot=1 -> single tick 6 cycles after the write; done[1]=1 and no further ticks for 50 cycles; rewriting ch1 clears done[1] and retriggers.
- Priority/boundaries: clear with cfg_we to ch2 (div=4) in the same cycle -> all counters restart, ch2 ticks 4 cycles later. cfg_ch=5 with NUM_CH=4 -> no state change. Write during the tick cycle -> no tick that cycle.
- Async reset mid-operation: assert reset_n low between edges while ch0 cnt=7 -> tick_out and done go 0 immediately; after release, div=DEFAULT_DIV and the first tick comes after 10 cycles.
